ex_branch_resolve: RTL

Execute-stage back end directly downstream of the ALU. Consumes the ALU result and flags (zero, neg, carry, overflow) plus instruction context, and resolves RV32I conditional branches, JAL and JALR. Issues a front-end redirect on taken control transfers and squashes wrong-path instructions. Forwards writeback results through a one-entry valid/ready output register.

---
 rtl/ex_branch_resolve.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ex_branch_resolve.sv
// ex_branch_resolve: execute-stage back end that resolves RV32I branches,
// JAL and JALR. It issues a front-end redirect on taken control transfers,
// squashes wrong-path beats while that redirect is pending, and forwards
// writeback results through a one-entry valid/ready output register.
// Optional build macro: BRANCH_STATS_EN adds the stat_branches and
// stat_taken counters.
module ex_branch_resolve #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_kind,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic [RD_W-1:0] in_rd,
   input  logic [XLEN-1:0] in_alu_out,
   input  logic            in_zero,
   input  logic            in_neg,
   input  logic            in_carry,
   input  logic            in_overflow,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [RD_W-1:0] out_rd,
   output logic [XLEN-1:0] out_data,
   output logic            redirect_valid,
   input  logic            redirect_ready,
   output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_taken
`endif
);

   localparam logic [1:0] KIND_ALU    = 2'd0;
   localparam logic [1:0] KIND_BRANCH = 2'd1;
   localparam logic [1:0] KIND_JAL    = 2'd2;
   localparam logic [1:0] KIND_JALR   = 2'd3;

   typedef enum logic {
      S_RUN,
      S_REDIRECT
   } state_t;

   state_t          state_q, state_d;
   logic            out_valid_q, out_valid_d;
   logic [RD_W-1:0] out_rd_q, out_rd_d;
   logic [XLEN-1:0] out_data_q, out_data_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic            accept_live;
   logic            taken;
   logic [XLEN-1:0] link_addr;
   logic [XLEN-1:0] rel_target;

   // Branch condition from the ALU flags of SUB rs1-rs2; 010/011 never taken.
   function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                         input logic n, input logic c,
                                         input logic v);
      logic t;
      case (f3)
         3'b000:  t = z;
         3'b001:  t = ~z;
         3'b100:  t = n ^ v;
         3'b101:  t = ~(n ^ v);
         3'b110:  t = c;
         3'b111:  t = ~c;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // Handshake, branch resolution and next-state for FSM, output entry and redirect.
   always_comb begin
      state_d       = state_q;
      out_valid_d   = out_valid_q & ~out_ready;
      out_rd_d      = out_rd_q;
      out_data_d    = out_data_q;
      redirect_pc_d = redirect_pc_q;

      // While a redirect is pending every beat is wrong-path, so it is always taken and dropped.
      in_ready    = (state_q == S_REDIRECT) | ~out_valid_q | out_ready;
      accept_live = in_valid & in_ready & (state_q == S_RUN);
      taken       = branch_taken(in_funct3, in_zero, in_neg, in_carry, in_overflow);
      link_addr   = in_pc + XLEN'(4);
      rel_target  = in_pc + in_imm;

      case (state_q)
         S_RUN: begin
            if (accept_live) begin
               case (in_kind)
                  KIND_ALU: begin
                     out_valid_d = 1'b1;
                     out_rd_d    = in_rd;
                     out_data_d  = in_alu_out;
                  end
                  KIND_BRANCH: begin
                     if (taken) begin
                        redirect_pc_d = rel_target;
                        state_d       = S_REDIRECT;
                     end
                  end
                  KIND_JAL: begin
                     out_valid_d   = 1'b1;
                     out_rd_d      = in_rd;
                     out_data_d    = link_addr;
                     redirect_pc_d = rel_target;
                     state_d       = S_REDIRECT;
                  end
                  KIND_JALR: begin
                     out_valid_d   = 1'b1;
                     out_rd_d      = in_rd;
                     out_data_d    = link_addr;
                     redirect_pc_d = {in_alu_out[XLEN-1:1], 1'b0};
                     state_d       = S_REDIRECT;
                  end
               endcase
            end
         end
         S_REDIRECT: begin
            if (redirect_ready) begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // State, output entry and redirect target registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_RUN;
         out_valid_q   <= 1'b0;
         out_rd_q      <= '0;
         out_data_q    <= '0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         out_rd_q      <= out_rd_d;
         out_data_q    <= out_data_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_rd         = out_rd_q;
   assign out_data       = out_data_q;
   assign redirect_valid = (state_q == S_REDIRECT);
   assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches_q, stat_branches_d;
   logic [31:0] stat_taken_q, stat_taken_d;

   // Count resolved (non-squashed) conditional branches and the taken subset.
   always_comb begin
      stat_branches_d = stat_branches_q;
      stat_taken_d    = stat_taken_q;
      if (accept_live && in_kind == KIND_BRANCH) begin
         stat_branches_d = stat_branches_q + 32'd1;
         if (taken) begin
            stat_taken_d = stat_taken_q + 32'd1;
         end
      end
   end

   // Statistics counter registers, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_branches_q <= '0;
         stat_taken_q    <= '0;
      end else begin
         stat_branches_q <= stat_branches_d;
         stat_taken_q    <= stat_taken_d;
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_taken    = stat_taken_q;
`endif

endmodule
